uart_rx_sampler: RTL and testbench
==================================

UART_RX_SAMPLER -- requirements
Module: uart_rx_sampler

Interface
REQ-001 SHALL have parameter PWIDTH, default 6: prescale and edge_counter width.
REQ-002 SHALL have parameter DWIDTH, default 8: data bits per frame.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port enable, input, 1: frame in progress; when high, edge/bit counters are running.
REQ-006 SHALL have port rx_in, input, 1: serial line, already synchronised to clk.
REQ-007 SHALL have port prescale, input, PWIDTH: oversampling ratio; legal values 8, 16, 32.
REQ-008 SHALL have port edge_counter, input, PWIDTH: sample tick within the current bit, 0..prescale-1.
REQ-009 SHALL have port bit_counter, input, PWIDTH-1: bit index within the frame (0 = start bit).
REQ-010 SHALL have port par_en, input, 1: parity bit present after the data bits.
REQ-011 SHALL have port par_typ, input, 1: 0 = even parity, 1 = odd parity.
REQ-012 SHALL have port sampled_bit, output, 1: majority-voted value of the last sampled bit.
REQ-013 SHALL have port sample_done, output, 1: one-cycle strobe; sampled_bit is newly valid.
REQ-014 SHALL have port p_data, output, DWIDTH: last good received byte.
REQ-015 SHALL have port data_valid, output, 1: one-cycle strobe; p_data has just been updated.
REQ-016 SHALL have ports par_err, stp_err and strt_glitch, each output, 1: one-cycle error strobes.

Function
REQ-017 SHALL take three samples of rx_in per bit: at edge_counter = prescale/2-2, prescale/2-1 and prescale/2 (8 -> 2,3,4; 16 -> 6,7,8).
REQ-018 SHALL register the 2-of-3 majority into sampled_bit and pulse sample_done on the clock edge after the third sample, i.e. while edge_counter = prescale/2+1.
REQ-019 SHALL NOT sample or strobe while enable is low, or while prescale is not 8, 16 or 32.
REQ-020 SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-021 IDLE -> START on the rising edge of enable.
REQ-022 START -> DATA on a start-bit sample_done with sampled_bit = 0.
REQ-023 START -> IDLE with a one-cycle strt_glitch pulse when that start sample is 1; this frame then produces no further strobes.
REQ-024 par_en and par_typ SHALL be latched at the start-bit sample_done and SHALL be ignored for the rest of the frame.
REQ-025 In DATA, each sample_done SHALL shift sampled_bit into the shift register LSB-first.
REQ-026 DATA SHALL end after DWIDTH samples: to PARITY if latched par_en = 1, otherwise to STOP.
REQ-027 PARITY: expected bit = XOR(data) for even parity, ~XOR(data) for odd; on mismatch, par_err SHALL pulse together with that sample_done.
REQ-028 STOP: a sampled 0 SHALL pulse stp_err together with that sample_done; the state then returns to IDLE.
REQ-029 On a stop-bit sample_done with no par_err and no stp_err in this frame, p_data SHALL load the shift register and data_valid SHALL pulse on the following cycle.
REQ-030 p_data SHALL hold its value until the next data_valid; an errored frame SHALL leave p_data unchanged.
REQ-031 If enable falls mid-frame, the next cycle SHALL be IDLE with the shift register cleared and no strobes issued.
REQ-032 If enable rises in the same cycle a frame completes, the new frame SHALL start normally.
REQ-033 Strobes SHALL never overlap across frames.
REQ-034 The state machine SHALL use bit_counter only as a consistency check: a mismatch with the internal phase SHALL abort to IDLE with no strobes.

Reset
REQ-035 While rst = 0, state SHALL be IDLE and sampled_bit, sample_done, data_valid, par_err, stp_err and strt_glitch SHALL be 0.
REQ-036 While rst = 0, p_data and the shift register SHALL be all-zero.
REQ-037 Reset SHALL take effect asynchronously and be released synchronously; assertion mid-frame discards the frame with no strobes.

Structure
REQ-038 The state encoding, legal prescale values and the parity-type encoding SHALL live in the shared package uart_rx_pkg.
REQ-039 The three-sample capture plus majority vote SHALL be the sub-module data_sampling (outputs sampled_bit, sample_done).
REQ-040 Frame sequencing, deserialisation and checking SHALL stay in uart_rx_sampler.

Verification
REQ-041 prescale = 8, par_en = 0, byte 0xA5 with a good stop bit -> eight DATA sample_done strobes, data_valid pulse, p_data = 0xA5, no error strobes.
REQ-042 prescale = 16, par_en = 1, par_typ = 0, byte 0x3C, parity bit 1 -> par_err pulse, no data_valid, p_data unchanged.
REQ-043 prescale = 8, start bit 0 at edge 2 only (1 at edges 3 and 4) -> strt_glitch pulse, return to IDLE, no data_valid.
REQ-044 prescale = 32, par_en = 1, par_typ = 1, byte 0x00, parity 1, stop 0 -> stp_err only, p_data unchanged.
REQ-045 enable dropped during data bit 4, then a new 0x5A frame -> no strobes for the first frame, p_data = 0x5A after the second.
REQ-046 rst pulsed low mid-frame -> all outputs 0 immediately; the next frame is received correctly.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: frame states, legal
// oversampling ratios, parity-type encoding and small helpers.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    typedef enum logic {
        PAR_EVEN = 1'b0,
        PAR_ODD  = 1'b1
    } par_type_e;

    localparam int PRESCALE_X8  = 8;
    localparam int PRESCALE_X16 = 16;
    localparam int PRESCALE_X32 = 32;

    function automatic logic prescale_legal(input int p);
        return (p == PRESCALE_X8) || (p == PRESCALE_X16) || (p == PRESCALE_X32);
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/data_sampling.sv
// Three-tap mid-bit capture of rx_in with a 2-of-3 majority vote; the voted
// bit and its strobe appear one cycle after the third tap.
module data_sampling
    import uart_rx_pkg::*;
#(
    parameter int PWIDTH = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              rx_in,
    input  logic [PWIDTH-1:0] prescale,
    input  logic [PWIDTH-1:0] edge_counter,
    output logic              sampled_bit,
    output logic              sample_done
);

    logic [PWIDTH-1:0] tick_a;
    logic [PWIDTH-1:0] tick_b;
    logic [PWIDTH-1:0] tick_c;
    logic              active;
    logic              samp_a;
    logic              samp_b;

    assign tick_c = prescale >> 1;
    assign tick_b = tick_c - PWIDTH'(1);
    assign tick_a = tick_c - PWIDTH'(2);
    assign active = enable && prescale_legal(int'(prescale));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            samp_a      <= 1'b0;
            samp_b      <= 1'b0;
            sampled_bit <= 1'b0;
            sample_done <= 1'b0;
        end else begin
            sample_done <= 1'b0;
            if (active) begin
                if (edge_counter == tick_a) samp_a <= rx_in;
                if (edge_counter == tick_b) samp_b <= rx_in;
                // Third tap is taken live and voted in the same edge.
                if (edge_counter == tick_c) begin
                    sampled_bit <= majority3(samp_a, samp_b, rx_in);
                    sample_done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/uart_rx_sampler.sv
// UART frame receiver: sequences start/data/parity/stop bits from the voted
// samples, deserialises LSB-first and raises one-cycle result/error strobes.
module uart_rx_sampler
    import uart_rx_pkg::*;
#(
    parameter int PWIDTH = 6,
    parameter int DWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              rx_in,
    input  logic [PWIDTH-1:0] prescale,
    input  logic [PWIDTH-1:0] edge_counter,
    input  logic [PWIDTH-2:0] bit_counter,
    input  logic              par_en,
    input  logic              par_typ,
    output logic              sampled_bit,
    output logic              sample_done,
    output logic [DWIDTH-1:0] p_data,
    output logic              data_valid,
    output logic              par_err,
    output logic              stp_err,
    output logic              strt_glitch
);

    localparam logic [PWIDTH-2:0] LAST_DATA_IDX = (PWIDTH-1)'(DWIDTH);
    localparam logic [PWIDTH-2:0] IDX_ONE       = (PWIDTH-1)'(1);

    rx_state_e         state;
    rx_state_e         state_nxt;
    logic              enable_d;
    logic              enable_rise;
    logic [PWIDTH-2:0] frame_idx;
    logic [DWIDTH-1:0] shift_q;
    logic              par_en_q;
    par_type_e         par_typ_q;
    logic              err_seen;
    logic              samp_en;
    logic              bit_ok;
    logic              exp_par;
    logic              shift_en;
    logic              frame_ok;

    assign enable_rise = enable & ~enable_d;
    // The sampler only runs once a frame has actually been opened.
    assign samp_en     = enable && (state != IDLE);
    assign bit_ok      = sample_done && enable && (bit_counter == frame_idx);
    assign exp_par     = (par_typ_q == PAR_ODD) ? ~(^shift_q) : ^shift_q;

    data_sampling #(.PWIDTH(PWIDTH)) u_data_sampling (
        .clk          (clk),
        .rst          (rst),
        .enable       (samp_en),
        .rx_in        (rx_in),
        .prescale     (prescale),
        .edge_counter (edge_counter),
        .sampled_bit  (sampled_bit),
        .sample_done  (sample_done)
    );

    always_comb begin
        state_nxt   = state;
        strt_glitch = 1'b0;
        par_err     = 1'b0;
        stp_err     = 1'b0;
        shift_en    = 1'b0;
        frame_ok    = 1'b0;
        case (state)
            IDLE:   if (enable_rise) state_nxt = START;
            START:  if (bit_ok) begin
                        strt_glitch = sampled_bit;
                        state_nxt   = sampled_bit ? IDLE : DATA;
                    end
            DATA:   if (bit_ok) begin
                        shift_en = 1'b1;
                        if (frame_idx == LAST_DATA_IDX)
                            state_nxt = par_en_q ? PARITY : STOP;
                    end
            PARITY: if (bit_ok) begin
                        par_err   = (sampled_bit != exp_par);
                        state_nxt = STOP;
                    end
            STOP:   if (bit_ok) begin
                        stp_err   = ~sampled_bit;
                        frame_ok  = sampled_bit & ~err_seen;
                        state_nxt = enable_rise ? START : IDLE;
                    end
            default: state_nxt = IDLE;
        endcase
        // Losing enable or disagreeing with the external bit index kills the frame.
        if (state != IDLE && (!enable || (sample_done && bit_counter != frame_idx)))
            state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            enable_d   <= 1'b0;
            frame_idx  <= '0;
            shift_q    <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= PAR_EVEN;
            err_seen   <= 1'b0;
            p_data     <= '0;
            data_valid <= 1'b0;
        end else begin
            state      <= state_nxt;
            enable_d   <= enable;
            data_valid <= frame_ok;
            if (frame_ok) p_data <= shift_q;
            if (state == START && bit_ok) begin
                par_en_q  <= par_en;
                par_typ_q <= par_type_e'(par_typ);
            end
            if (state_nxt == START && state != START) begin
                frame_idx <= '0;
                shift_q   <= '0;
                err_seen  <= 1'b0;
            end else if (state_nxt == IDLE) begin
                frame_idx <= '0;
                shift_q   <= '0;
            end else begin
                if (bit_ok) frame_idx <= frame_idx + IDX_ONE;
                if (shift_en) shift_q <= {sampled_bit, shift_q[DWIDTH-1:1]};
                if (par_err) err_seen <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Directed frame-level bench for uart_rx_sampler: drives edge/bit counters,
// counts the output strobes per frame and compares against hand-worked values.
module tb_uart_rx_sampler;

    localparam int PW = 6;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          rx_in;
    logic [PW-1:0] prescale;
    logic [PW-1:0] edge_counter;
    logic [PW-2:0] bit_counter;
    logic          par_en;
    logic          par_typ;
    logic          sampled_bit;
    logic          sample_done;
    logic [DW-1:0] p_data;
    logic          data_valid;
    logic          par_err;
    logic          stp_err;
    logic          strt_glitch;

    int n_checks = 0;
    int n_fail   = 0;
    int sd_cnt, dv_cnt, pe_cnt, se_cnt, sg_cnt;

    always #5 clk = ~clk;

    uart_rx_sampler #(.PWIDTH(PW), .DWIDTH(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .rx_in        (rx_in),
        .prescale     (prescale),
        .edge_counter (edge_counter),
        .bit_counter  (bit_counter),
        .par_en       (par_en),
        .par_typ      (par_typ),
        .sampled_bit  (sampled_bit),
        .sample_done  (sample_done),
        .p_data       (p_data),
        .data_valid   (data_valid),
        .par_err      (par_err),
        .stp_err      (stp_err),
        .strt_glitch  (strt_glitch)
    );

    always @(negedge clk) begin
        if (sample_done) sd_cnt++;
        if (data_valid)  dv_cnt++;
        if (par_err)     pe_cnt++;
        if (stp_err)     se_cnt++;
        if (strt_glitch) sg_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        sd_cnt = 0; dv_cnt = 0; pe_cnt = 0; se_cnt = 0; sg_cnt = 0;
    endtask

    // abort_mode: 0 none, 1 drop enable, 2 pulse reset; both at edge 3 of abort_bit.
    task automatic send_frame(input int ps, input logic [7:0] data, input logic pen,
                              input logic ptyp, input logic pbit, input logic stopb,
                              input int abort_mode, input int abort_bit,
                              input int glitch, input int bc_skip);
        logic bits [12];
        int   nb;
        logic stop_now;
        clear_counts();
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = data[i];
        nb = 9;
        if (pen) begin bits[nb] = pbit; nb++; end
        bits[nb] = stopb;
        nb++;
        prescale = PW'(ps);
        par_en   = pen;
        par_typ  = ptyp;
        stop_now = 1'b0;
        for (int b = 0; b < nb && !stop_now; b++) begin
            for (int e = 0; e < ps && !stop_now; e++) begin
                if (abort_mode != 0 && b == abort_bit && e == 3) begin
                    stop_now = 1'b1;
                    enable   = 1'b0;
                    if (abort_mode == 2) begin
                        rst = 1'b0;
                        #1;
                        check_eq("rst_mid_p_data", 32'(p_data), 32'h0);
                        check_eq("rst_mid_strobes",
                                 {sample_done, data_valid, par_err, stp_err, strt_glitch}, 0);
                        check_eq("rst_mid_sampled_bit", sampled_bit, 0);
                        tick();
                        tick();
                        rst = 1'b1;
                    end
                end else begin
                    enable       = 1'b1;
                    edge_counter = PW'(e);
                    bit_counter  = (PW-1)'(b + ((bc_skip >= 0 && b >= bc_skip) ? 1 : 0));
                    rx_in        = (glitch != 0 && b == 0) ? logic'(e != 2) : bits[b];
                    tick();
                end
            end
        end
        enable       = 1'b0;
        edge_counter = '0;
        bit_counter  = '0;
        rx_in        = 1'b1;
        repeat (4) tick();
    endtask

    initial begin
        rst          = 1'b0;
        enable       = 1'b0;
        rx_in        = 1'b1;
        prescale     = PW'(8);
        edge_counter = '0;
        bit_counter  = '0;
        par_en       = 1'b0;
        par_typ      = 1'b0;
        clear_counts();
        repeat (3) tick();
        check_eq("reset_sampled_bit", sampled_bit, 0);
        check_eq("reset_sample_done", sample_done, 0);
        check_eq("reset_data_valid", data_valid, 0);
        check_eq("reset_p_data", 32'(p_data), 32'h0);
        check_eq("reset_err_strobes", {par_err, stp_err, strt_glitch}, 0);
        rst = 1'b1;
        tick();

        // x8, no parity, 0xA5 good stop
        send_frame(8, 8'hA5, 0, 0, 0, 1, 0, 0, 0, -1);
        check_eq("a5_data_valid_cnt", dv_cnt, 1);
        check_eq("a5_p_data", 32'(p_data), 32'hA5);
        check_eq("a5_err_cnt", pe_cnt + se_cnt + sg_cnt, 0);
        check_eq("a5_sample_done_cnt", sd_cnt, 10);
        check_eq("a5_last_sampled_bit", sampled_bit, 1);

        // x16, even parity, 0x3C with wrong parity bit 1
        send_frame(16, 8'h3C, 1, 0, 1, 1, 0, 0, 0, -1);
        check_eq("par_bad_par_err_cnt", pe_cnt, 1);
        check_eq("par_bad_data_valid_cnt", dv_cnt, 0);
        check_eq("par_bad_p_data", 32'(p_data), 32'hA5);
        check_eq("par_bad_stp_err_cnt", se_cnt, 0);
        check_eq("par_bad_sample_done_cnt", sd_cnt, 11);

        // x8, start bit low only at edge 2
        send_frame(8, 8'h00, 0, 0, 0, 1, 0, 0, 1, -1);
        check_eq("glitch_cnt", sg_cnt, 1);
        check_eq("glitch_data_valid_cnt", dv_cnt, 0);
        check_eq("glitch_sample_done_cnt", sd_cnt, 1);

        // x32, odd parity, 0x00 parity 1 (good), stop 0
        send_frame(32, 8'h00, 1, 1, 1, 0, 0, 0, 0, -1);
        check_eq("stop_bad_stp_err_cnt", se_cnt, 1);
        check_eq("stop_bad_par_err_cnt", pe_cnt, 0);
        check_eq("stop_bad_data_valid_cnt", dv_cnt, 0);
        check_eq("stop_bad_p_data", 32'(p_data), 32'hA5);

        // x8, even parity, 0x3C with correct parity bit 0
        send_frame(8, 8'h3C, 1, 0, 0, 1, 0, 0, 0, -1);
        check_eq("par_good_data_valid_cnt", dv_cnt, 1);
        check_eq("par_good_p_data", 32'(p_data), 32'h3C);
        check_eq("par_good_par_err_cnt", pe_cnt, 0);

        // enable dropped during data bit 4, then a clean 0x5A frame
        send_frame(16, 8'hFF, 0, 0, 0, 1, 1, 5, 0, -1);
        check_eq("drop_strobe_cnt", dv_cnt + pe_cnt + se_cnt + sg_cnt, 0);
        check_eq("drop_p_data", 32'(p_data), 32'h3C);
        send_frame(16, 8'h5A, 0, 0, 0, 1, 0, 0, 0, -1);
        check_eq("after_drop_data_valid_cnt", dv_cnt, 1);
        check_eq("after_drop_p_data", 32'(p_data), 32'h5A);

        // illegal prescale: nothing sampled
        send_frame(12, 8'h81, 0, 0, 0, 1, 0, 0, 0, -1);
        check_eq("bad_prescale_sample_done_cnt", sd_cnt, 0);
        check_eq("bad_prescale_data_valid_cnt", dv_cnt, 0);

        // bit_counter jumps ahead at bit 3 -> abort
        send_frame(8, 8'h81, 0, 0, 0, 1, 0, 0, 0, 3);
        check_eq("bc_skip_strobe_cnt", dv_cnt + pe_cnt + se_cnt + sg_cnt, 0);
        check_eq("bc_skip_p_data", 32'(p_data), 32'h5A);

        // reset pulsed mid-frame, then a clean 0xC3 frame
        send_frame(8, 8'hF0, 0, 0, 0, 1, 2, 3, 0, -1);
        check_eq("rst_frame_data_valid_cnt", dv_cnt, 0);
        send_frame(8, 8'hC3, 0, 0, 0, 1, 0, 0, 0, -1);
        check_eq("after_rst_data_valid_cnt", dv_cnt, 1);
        check_eq("after_rst_p_data", 32'(p_data), 32'hC3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
